// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the CPU bus memory responder.
package bus_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrive,
        StDone
    } state_e;

    localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;
    localparam logic       CODE_SPACE    = 1'b0;
    localparam logic       XDATA_SPACE   = 1'b1;

    // True when every address bit at or above aw is zero.
    function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned aw);
        return (aw >= 16) || ((addr >> aw) == 16'd0);
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// CPU-side strobe/address/status signals of the memory responder.
interface bus_mem_responder_if;

    logic [15:0] addr_bus;
    logic        read_en;
    logic        write_en;
    logic        memory_select;
    logic        err_clr;
    logic        ack;
    logic        err;

    modport master (
        output addr_bus, read_en, write_en, memory_select, err_clr,
        input  ack, err
    );

    modport slave (
        input  addr_bus, read_en, write_en, memory_select, err_clr,
        output ack, err
    );

endinterface

// File: rtl/sp_ram.sv
// Single-port-write RAM with one synchronous, read-enabled read port.
module sp_ram #(
    parameter int unsigned Width     = 8,
    parameter int unsigned AddrWidth = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [Width-1:0]     wdata,
    input  logic                 re,
    input  logic [AddrWidth-1:0] raddr,
    output logic [Width-1:0]     rdata
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [Width-1:0] mem [Depth];

    // Read-before-write: a same-edge read of a written address returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Wait-stated memory responder for a CPU bus: code space (preloadable, read-only
// from the bus) and XDATA space, with a tri-stated read data bus and sticky error.
module bus_mem_responder
    import bus_mem_pkg::*;
#(
    parameter int unsigned CODE_AW     = 10,
    parameter int unsigned XDATA_AW    = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_mem_responder_if.slave bus,
    inout  wire  [7:0]         data_bus,
    input  logic               load_en,
    input  logic [CODE_AW-1:0] load_addr,
    input  logic [7:0]         load_data
);

    localparam logic [2:0] WaitInit = 3'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] addr_q;
    logic        space_q;
    logic        is_write_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rd_q, rd_d;
    logic        ack_q, ack_d;
    logic        err_q, err_set;

    logic        start;
    logic        strobe;
    logic        addr_ok;
    logic        xdata_we;
    logic [7:0]  code_rdata;
    logic [7:0]  xdata_rdata;

    assign start   = (state_q == StIdle) && (bus.read_en ^ bus.write_en);
    assign addr_ok = (space_q == XDATA_SPACE) ? addr_in_range(addr_q, XDATA_AW)
                                              : addr_in_range(addr_q, CODE_AW);

    // Both RAMs sample on the start edge so a concurrent preload sees the old byte.
    sp_ram #(
        .Width     (8),
        .AddrWidth (CODE_AW)
    ) u_code_ram (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (start),
        .raddr (bus.addr_bus[CODE_AW-1:0]),
        .rdata (code_rdata)
    );

    sp_ram #(
        .Width     (8),
        .AddrWidth (XDATA_AW)
    ) u_xdata_ram (
        .clk   (clk),
        .we    (xdata_we),
        .waddr (addr_q[XDATA_AW-1:0]),
        .wdata (wdata_q),
        .re    (start),
        .raddr (bus.addr_bus[XDATA_AW-1:0]),
        .rdata (xdata_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rd_d       = rd_q;
        ack_d      = 1'b0;
        err_set    = 1'b0;
        xdata_we   = 1'b0;
        strobe     = is_write_q ? bus.write_en : bus.read_en;
        case (state_q)
            StIdle: begin
                if (bus.read_en && bus.write_en) begin
                    err_set = 1'b1;
                end else if (start) begin
                    state_d    = StWait;
                    wait_cnt_d = WaitInit;
                end
            end
            StWait: begin
                if (!strobe) begin
                    state_d = StIdle;
                end else if (wait_cnt_q != 3'd0) begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end else begin
                    ack_d = 1'b1;
                    if (is_write_q) begin
                        state_d = StDone;
                        if (addr_ok && (space_q == XDATA_SPACE)) begin
                            xdata_we = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                    end else begin
                        state_d = StDrive;
                        if (addr_ok) begin
                            rd_d = (space_q == XDATA_SPACE) ? xdata_rdata : code_rdata;
                        end else begin
                            rd_d    = BUS_IDLE_DATA;
                            err_set = 1'b1;
                        end
                    end
                end
            end
            StDrive: begin
                if (!bus.read_en) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (!bus.write_en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 3'd0;
            addr_q     <= 16'd0;
            space_q    <= CODE_SPACE;
            is_write_q <= 1'b0;
            wdata_q    <= 8'd0;
            rd_q       <= 8'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_q       <= rd_d;
            ack_q      <= ack_d;
            err_q      <= err_set | (err_q & ~bus.err_clr);
            if (start) begin
                addr_q     <= bus.addr_bus;
                space_q    <= bus.memory_select;
                is_write_q <= bus.write_en;
                wdata_q    <= data_bus;
            end
        end
    end

    assign bus.ack  = ack_q;
    assign bus.err  = err_q;
    assign data_bus = ((state_q == StDrive) && bus.read_en) ? rd_q : 8'hzz;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench: stimulus queues expected acks, a negedge monitor checks them.
module tb_bus_mem_responder;
    import bus_mem_pkg::*;

    typedef struct packed {
        logic       is_read;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t exp_q [2][$];

    logic [15:0] addr    [2];
    logic        rd_en   [2];
    logic        wr_en   [2];
    logic        sel     [2];
    logic        clr     [2];
    logic        drv_en  [2];
    logic [7:0]  drv     [2];
    logic        ld_en   [2];
    logic [9:0]  ld_addr [2];
    logic [7:0]  ld_data [2];

    wire [7:0] data_bus0;
    wire [7:0] data_bus1;
    assign data_bus0 = drv_en[0] ? drv[0] : 8'hzz;
    assign data_bus1 = drv_en[1] ? drv[1] : 8'hzz;

    bus_mem_responder_if if0 ();
    bus_mem_responder_if if1 ();
    assign if0.addr_bus      = addr[0];
    assign if0.read_en       = rd_en[0];
    assign if0.write_en      = wr_en[0];
    assign if0.memory_select = sel[0];
    assign if0.err_clr       = clr[0];
    assign if1.addr_bus      = addr[1];
    assign if1.read_en       = rd_en[1];
    assign if1.write_en      = wr_en[1];
    assign if1.memory_select = sel[1];
    assign if1.err_clr       = clr[1];

    bus_mem_responder #(.CODE_AW(10), .XDATA_AW(8), .WAIT_STATES(1)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if0),
        .data_bus  (data_bus0),
        .load_en   (ld_en[0]),
        .load_addr (ld_addr[0]),
        .load_data (ld_data[0])
    );

    bus_mem_responder #(.CODE_AW(10), .XDATA_AW(8), .WAIT_STATES(3)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if1),
        .data_bus  (data_bus1),
        .load_en   (ld_en[1]),
        .load_addr (ld_addr[1]),
        .load_data (ld_data[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] bus_val(input int d);
        return (d == 0) ? data_bus0 : data_bus1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Probe for hi-Z: the bench drives a pattern that only reads back if the DUT is off the bus.
    task automatic check_hiz(input int d, input string name);
        drv_en[d] = 1'b1;
        drv[d]    = 8'h3C;
        @(negedge clk);
        check(name, 32'(bus_val(d)), 32'h3C);
        #1 drv_en[d] = 1'b0;
    endtask

    task automatic load(input int d, input logic [9:0] a, input logic [7:0] v);
        ld_en[d]   = 1'b1;
        ld_addr[d] = a;
        ld_data[d] = v;
        step(1);
        ld_en[d]   = 1'b0;
    endtask

    task automatic start_acc(input int d, input bit w, input logic s, input logic [15:0] a,
                             input logic [7:0] wd);
        addr[d] = a;
        sel[d]  = s;
        if (w) begin
            wr_en[d]  = 1'b1;
            drv_en[d] = 1'b1;
            drv[d]    = wd;
        end else begin
            rd_en[d] = 1'b1;
        end
    endtask

    // Ack is due 1+WAIT_STATES cycles after the start edge, i.e. cyc+2+ws at the monitor.
    task automatic expect_ack(input int d, input bit is_rd, input logic [7:0] v);
        exp_t e;
        e.is_read = is_rd;
        e.data    = v;
        e.due     = cyc + 2 + ws_of(d);
        exp_q[d].push_back(e);
    endtask

    task automatic access(input int d, input bit w, input logic s, input logic [15:0] a,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        start_acc(d, w, s, a, wd);
        expect_ack(d, !w, exp_rd);
        step(3 + ws_of(d));
        if (w) begin
            wr_en[d]  = 1'b0;
            drv_en[d] = 1'b0;
        end else begin
            rd_en[d] = 1'b0;
            check_hiz(d, "hiz_after_read");
        end
        step(1);
    endtask

    task automatic clear_err(input int d);
        clr[d] = 1'b1;
        step(1);
        clr[d] = 1'b0;
    endtask

    task automatic mon(input int d, input logic a);
        exp_t e;
        if (a) begin
            check("ack_expected", 32'(exp_q[d].size() != 0), 32'd1);
            if (exp_q[d].size() != 0) begin
                e = exp_q[d].pop_front();
                check("ack_cycle", cyc, e.due);
                if (e.is_read) begin
                    check("read_data", 32'(bus_val(d)), 32'(e.data));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if0.ack);
            mon(1, if1.ack);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            addr[d] = 16'd0; rd_en[d] = 1'b0; wr_en[d] = 1'b0; sel[d] = 1'b0;
            clr[d] = 1'b0; drv_en[d] = 1'b0; drv[d] = 8'd0;
            ld_en[d] = 1'b0; ld_addr[d] = 10'd0; ld_data[d] = 8'd0;
        end
        rst_n = 1'b0;
        step(2);
        check("reset_ack0", 32'(if0.ack), 32'd0);
        check("reset_err0", 32'(if0.err), 32'd0);
        check("reset_ack1", 32'(if1.ack), 32'd0);
        check("reset_err1", 32'(if1.err), 32'd0);
        check_hiz(0, "reset_hiz0");
        check_hiz(1, "reset_hiz1");
        rst_n = 1'b1;
        step(1);

        // Preloaded code read, XDATA write/readback.
        load(0, 10'h010, 8'hB4);
        load(0, 10'h005, 8'h11);
        access(0, 1'b0, CODE_SPACE, 16'h0010, 8'h00, 8'hB4);
        access(0, 1'b1, XDATA_SPACE, 16'h0020, 8'h50, 8'h00);
        access(0, 1'b0, XDATA_SPACE, 16'h0020, 8'h00, 8'h50);
        check("err_clean", 32'(if0.err), 32'd0);

        // Code-space write is acked but dropped.
        access(0, 1'b1, CODE_SPACE, 16'h0005, 8'h77, 8'h00);
        check("err_code_write", 32'(if0.err), 32'd1);
        clear_err(0);
        check("err_cleared", 32'(if0.err), 32'd0);
        access(0, 1'b0, CODE_SPACE, 16'h0005, 8'h00, 8'h11);

        // Out-of-range accesses.
        access(0, 1'b0, XDATA_SPACE, 16'h0100, 8'h00, 8'hFF);
        check("err_xdata_range", 32'(if0.err), 32'd1);
        clear_err(0);
        access(0, 1'b0, CODE_SPACE, 16'h0400, 8'h00, 8'hFF);
        check("err_code_range", 32'(if0.err), 32'd1);
        clear_err(0);
        access(0, 1'b1, XDATA_SPACE, 16'h0120, 8'h99, 8'h00);
        check("err_xdata_wr_range", 32'(if0.err), 32'd1);
        clear_err(0);
        access(0, 1'b0, XDATA_SPACE, 16'h0020, 8'h00, 8'h50);

        // Both strobes together, with err_clr in the same cycle.
        start_acc(0, 1'b1, XDATA_SPACE, 16'h0020, 8'hAA);
        rd_en[0] = 1'b1;
        clr[0]   = 1'b1;
        step(1);
        check("err_set_beats_clr", 32'(if0.err), 32'd1);
        clr[0] = 1'b0;
        step(2);
        check("err_sticky", 32'(if0.err), 32'd1);
        rd_en[0] = 1'b0; wr_en[0] = 1'b0; drv_en[0] = 1'b0;
        step(1);
        clear_err(0);
        check("err_cleared2", 32'(if0.err), 32'd0);
        access(0, 1'b0, XDATA_SPACE, 16'h0020, 8'h00, 8'h50);

        // Preload on the start edge of a read of the same byte returns the old value.
        start_acc(0, 1'b0, CODE_SPACE, 16'h0010, 8'h00);
        expect_ack(0, 1'b1, 8'hB4);
        load(0, 10'h010, 8'hC3);
        step(2 + ws_of(0));
        rd_en[0] = 1'b0;
        check_hiz(0, "hiz_after_collide");
        step(1);
        access(0, 1'b0, CODE_SPACE, 16'h0010, 8'h00, 8'hC3);

        // Reset while driving.
        start_acc(0, 1'b0, CODE_SPACE, 16'h0010, 8'h00);
        expect_ack(0, 1'b1, 8'hC3);
        step(3 + ws_of(0));
        check("drive_active", 32'(data_bus0), 32'hC3);
        rst_n = 1'b0;
        check("reset_drive_ack", 32'(if0.ack), 32'd0);
        check_hiz(0, "reset_drive_hiz");
        rd_en[0] = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);

        // Reset in the wait phase of a write must not commit it.
        start_acc(0, 1'b1, XDATA_SPACE, 16'h0020, 8'hEE);
        step(1);
        rst_n = 1'b0;
        check_hiz(0, "reset_wait_hiz");
        step(1);
        wr_en[0] = 1'b0; drv_en[0] = 1'b0;
        rst_n = 1'b1;
        step(1);
        check("err_after_reset", 32'(if0.err), 32'd0);
        access(0, 1'b0, XDATA_SPACE, 16'h0020, 8'h00, 8'h50);
        access(0, 1'b0, CODE_SPACE, 16'h0010, 8'h00, 8'hC3);

        // Three wait states: aborted read, then normal accesses.
        load(1, 10'h030, 8'h5A);
        start_acc(1, 1'b0, CODE_SPACE, 16'h0030, 8'h00);
        step(1);
        check_hiz(1, "abort_wait_hiz");
        rd_en[1] = 1'b0;
        step(6);
        check_hiz(1, "abort_after_hiz");
        step(1);
        access(1, 1'b0, CODE_SPACE, 16'h0030, 8'h00, 8'h5A);
        access(1, 1'b1, XDATA_SPACE, 16'h0007, 8'h3E, 8'h00);
        access(1, 1'b0, XDATA_SPACE, 16'h0007, 8'h00, 8'h3E);

        step(3);
        check("pending_acks0", 32'(exp_q[0].size()), 32'd0);
        check("pending_acks1", 32'(exp_q[1].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
